// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin mux arbiter: FSM encoding and requester geometry.
package mux_arb_pkg;
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam int   NREQ  = 8;
  localparam int   SELW  = 3;
endpackage

// File: rtl/Mux.sv
// Structural 8:1 single-bit mux; s1 is the select MSB, b1 is chosen by select 0.
// Purely combinational, no latency, no flow control.
module Mux (
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  input  logic b6,
  input  logic b7,
  input  logic b8,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  output logic a1
);
  assign a1 = (~s1 & ~s2 & ~s3 & b1) |
              (~s1 & ~s2 &  s3 & b2) |
              (~s1 &  s2 & ~s3 & b3) |
              (~s1 &  s2 &  s3 & b4) |
              ( s1 & ~s2 & ~s3 & b5) |
              ( s1 & ~s2 &  s3 & b6) |
              ( s1 &  s2 & ~s3 & b7) |
              ( s1 &  s2 &  s3 & b8);
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the shared 8:1 Mux; grant registered one cycle after a request,
// bursts capped at MAX_BURST beats, stalls indefinitely while out_ready is low and the request holds.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] data,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic            busy
);

  logic            state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [SELW-1:0] sel_nxt, last, last_nxt;
  logic [CW-1:0]   beat_cnt, cnt_nxt;
  logic            found;
  logic [SELW-1:0] pick, idx;

  // Search starts just after the last-served index; the 3-bit add wraps mod 8,
  // and the eighth probe lands back on last so a lone repeat requester still wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + SELW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last     <= SELW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    last_nxt  = last;
    cnt_nxt   = beat_cnt;
    if (state == IDLE) begin
      if (found) begin
        state_nxt = GRANT;
        gnt_nxt   = NREQ'(1) << pick;
        sel_nxt   = pick;
        last_nxt  = pick;
        cnt_nxt   = '0;
      end
    end else begin
      if (!req[sel]) begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end else if (out_ready) begin
        if (beat_cnt == CW'(MAX_BURST - 1)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy      = (state == GRANT);
    out_valid = (state == GRANT) && req[sel];
  end

  Mux u_mux (
    .b1 (data[0]),
    .b2 (data[1]),
    .b3 (data[2]),
    .b4 (data[3]),
    .b5 (data[4]),
    .b6 (data[5]),
    .b7 (data[6]),
    .b8 (data[7]),
    .s1 (sel[2]),
    .s2 (sel[1]),
    .s3 (sel[0]),
    .a1 (out_data)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with MAX_BURST=4: reset, bursts, rotation, stalls, drops, mux mapping, async reset.
module tb_rr_mux_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic       out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.MAX_BURST(4), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic e_bits [0:7];

  initial begin
    e_bits = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; req = '0; data = '0; out_ready = 1'b0;
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", {5'b0, sel}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_vld", {7'b0, out_valid}, 8'h00);

    // single requester 0, four beats, one idle cycle, re-grant
    step();
    rst_n = 1'b1; req = 8'h01; data = 8'h01; out_ready = 1'b1;
    #1;
    chk("idle_vld", {7'b0, out_valid}, 8'h00);
    step();
    chk("r0_busy", {7'b0, busy}, 8'h01);
    for (int b = 0; b < 4; b++) begin
      chk("r0_gnt", gnt, 8'h01);
      chk("r0_sel", {5'b0, sel}, 8'h00);
      chk("r0_vld", {7'b0, out_valid}, 8'h01);
      chk("r0_dat", {7'b0, out_data}, 8'h01);
      step();
    end
    chk("r0_gap_busy", {7'b0, busy}, 8'h00);
    chk("r0_gap_gnt", gnt, 8'h00);
    chk("r0_gap_vld", {7'b0, out_valid}, 8'h00);
    step();
    chk("r0_regrant", gnt, 8'h01);

    // all requesting: rotation 0..7,0 from a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step();
      for (int b = 0; b < 4; b++) begin
        chk("rot_gnt", gnt, 8'h01 << (g % 8));
        chk("rot_sel", {5'b0, sel}, 8'(g % 8));
        chk("rot_vld", {7'b0, out_valid}, 8'h01);
        step();
      end
      chk("rot_gap", {7'b0, busy}, 8'h00);
    end

    // requester 5: one beat, 10-cycle stall, then the remaining 3 beats
    req = 8'h20;
    step();
    chk("stall_gnt", gnt, 8'h20);
    chk("stall_sel", {5'b0, sel}, 8'h05);
    step();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("stall_hold_gnt", gnt, 8'h20);
      chk("stall_hold_vld", {7'b0, out_valid}, 8'h01);
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int b = 0; b < 3; b++) begin
      chk("stall_rest_busy", {7'b0, busy}, 8'h01);
      step();
    end
    chk("stall_end", {7'b0, busy}, 8'h00);

    // requester 3 drops after two beats; next grant wraps past 4..7 to 0
    req = 8'h08;
    step();
    chk("drop_gnt", gnt, 8'h08);
    chk("drop_sel", {5'b0, sel}, 8'h03);
    step();
    step();
    req = 8'h05;
    #1;
    chk("drop_vld", {7'b0, out_valid}, 8'h00);
    chk("drop_busy", {7'b0, busy}, 8'h01);
    step();
    chk("drop_idle", {7'b0, busy}, 8'h00);
    chk("drop_idle_gnt", gnt, 8'h00);
    step();
    chk("wrap_gnt", gnt, 8'h01);
    chk("wrap_sel", {5'b0, sel}, 8'h00);
    req = 8'h00;
    step();
    chk("wrap_idle", {7'b0, busy}, 8'h00);

    // mux mapping: each requester alone, out_data tracks data[k] combinationally
    data = 8'b1001_0111;
    for (int k = 0; k < 8; k++) begin
      req = 8'h01 << k;
      step();
      chk("mux_sel", {5'b0, sel}, 8'(k));
      chk("mux_dat", {7'b0, out_data}, {7'b0, e_bits[k]});
      data = ~data;
      #1;
      chk("mux_dat_inv", {7'b0, out_data}, {7'b0, ~e_bits[k]});
      data = ~data;
      req = 8'h00;
      step();
    end

    // async reset mid-burst of requester 6
    req = 8'h40;
    step();
    chk("ar_gnt", gnt, 8'h40);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt0", gnt, 8'h00);
    chk("ar_sel0", {5'b0, sel}, 8'h00);
    chk("ar_busy0", {7'b0, busy}, 8'h00);
    chk("ar_vld0", {7'b0, out_valid}, 8'h00);
    req = 8'hC1;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_first_gnt", gnt, 8'h01);
    chk("ar_first_sel", {5'b0, sel}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
